// File: rtl/program_feeder.sv
// Program feeder: replays a stored program into the processor's D input and generates its STEP clock.
// One STEP pulse per timestep; PC advances only on steps where the processor reads D.
module program_feeder #(
  parameter int DEPTH   = 16,
  parameter int STEP_LO = 4,
  parameter int STEP_HI = 4,
  parameter int MAX_T   = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          CLK50M,
  input  logic          RSTn,
  input  logic          WR_EN,
  input  logic [AW-1:0] WR_ADDR,
  input  logic [9:0]    WR_DATA,
  input  logic [AW:0]   PROG_LEN,
  input  logic          START,
  input  logic          EXT,
  input  logic          DONE,
  output logic [9:0]    D_OUT,
  output logic          STEP,
  output logic [AW-1:0] PC,
  output logic [7:0]    INSTR_CNT,
  output logic          BUSY,
  output logic          FINISHED,
  output logic          ERR
);

  // state   | meaning
  // S_IDLE  | after reset; program memory writable
  // S_SETUP | STEP low for STEP_LO cycles; EXT/DONE sampled on the last one
  // S_PULSE | STEP high for STEP_HI cycles; PC/counters update on exit
  // S_FIN   | program completed; waits for START
  // S_ERROR | instruction exceeded MAX_T steps; waits for START
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_FIN, S_ERROR} state_t;

  localparam int TMAX = (STEP_LO > STEP_HI) ? STEP_LO : STEP_HI;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int SW   = $clog2(MAX_T + 1);

  state_t        state;
  logic [9:0]    mem [DEPTH];
  logic [AW:0]   len;
  logic [TW-1:0] timer;
  logic [SW-1:0] tstep;
  logic          ext_s;
  logic          done_s;
  logic [AW:0]   pc_new;
  logic [SW-1:0] tstep_inc;

  assign D_OUT = mem[PC];

  // Kept one bit wider than PC so a run ending on the last word still sees PC >= len.
  assign pc_new    = ext_s ? ({1'b0, PC} + (AW+1)'(1)) : {1'b0, PC};
  assign tstep_inc = tstep + SW'(1);

  always_ff @(posedge CLK50M) begin
    if (WR_EN && state == S_IDLE) mem[WR_ADDR] <= WR_DATA;
  end

  always_ff @(posedge CLK50M or negedge RSTn) begin
    if (!RSTn) begin
      state     <= S_IDLE;
      PC        <= '0;
      INSTR_CNT <= '0;
      len       <= '0;
      timer     <= '0;
      tstep     <= '0;
      ext_s     <= 1'b0;
      done_s    <= 1'b0;
      STEP      <= 1'b0;
      BUSY      <= 1'b0;
      FINISHED  <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_FIN, S_ERROR: begin
          if (START) begin
            len       <= PROG_LEN;
            PC        <= '0;
            INSTR_CNT <= '0;
            tstep     <= '0;
            timer     <= TW'(STEP_LO - 1);
            ERR       <= 1'b0;
            if (PROG_LEN == '0) begin
              state    <= S_FIN;
              FINISHED <= 1'b1;
            end else begin
              state    <= S_SETUP;
              FINISHED <= 1'b0;
              BUSY     <= 1'b1;
            end
          end
        end
        S_SETUP: begin
          if (timer == '0) begin
            ext_s  <= EXT;
            done_s <= DONE;
            timer  <= TW'(STEP_HI - 1);
            STEP   <= 1'b1;
            state  <= S_PULSE;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_PULSE: begin
          if (timer != '0) begin
            timer <= timer - TW'(1);
          end else begin
            STEP  <= 1'b0;
            PC    <= pc_new[AW-1:0];
            timer <= TW'(STEP_LO - 1);
            if (done_s) begin
              if (INSTR_CNT != 8'hFF) INSTR_CNT <= INSTR_CNT + 8'd1;
              tstep <= '0;
            end else begin
              tstep <= tstep_inc;
            end
            // Completion wins over timeout when DONE lands on the MAX_T-th step.
            if (done_s && pc_new >= len) begin
              state    <= S_FIN;
              BUSY     <= 1'b0;
              FINISHED <= 1'b1;
            end else if (!done_s && tstep_inc == SW'(MAX_T)) begin
              state <= S_ERROR;
              BUSY  <= 1'b0;
              ERR   <= 1'b1;
            end else begin
              state <= S_SETUP;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_feeder.sv
// Bench for program_feeder: randomized processor step plans against a queue-based scoreboard.
// Expected pulses/outcomes are computed from a step-level model; a negedge monitor pops and compares.
module tb_program_feeder;
  localparam int DEPTH = 16, STEP_LO = 4, STEP_HI = 4, MAX_T = 8, AW = 4;

  logic          CLK50M = 1'b0;
  logic          RSTn = 1'b0;
  logic          WR_EN = 1'b0;
  logic [AW-1:0] WR_ADDR = '0;
  logic [9:0]    WR_DATA = '0;
  logic [AW:0]   PROG_LEN = '0;
  logic          START = 1'b0;
  logic          EXT = 1'b0;
  logic          DONE = 1'b0;
  logic [9:0]    D_OUT;
  logic          STEP;
  logic [AW-1:0] PC;
  logic [7:0]    INSTR_CNT;
  logic          BUSY;
  logic          FINISHED;
  logic          ERR;

  program_feeder #(.DEPTH(DEPTH), .STEP_LO(STEP_LO), .STEP_HI(STEP_HI), .MAX_T(MAX_T)) dut (
    .CLK50M(CLK50M), .RSTn(RSTn), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .PROG_LEN(PROG_LEN), .START(START), .EXT(EXT), .DONE(DONE), .D_OUT(D_OUT), .STEP(STEP),
    .PC(PC), .INSTR_CNT(INSTR_CNT), .BUSY(BUSY), .FINISHED(FINISHED), .ERR(ERR)
  );

  always #5 CLK50M = ~CLK50M;

  typedef struct { logic [9:0] d; logic [AW-1:0] pc; } pulse_t;
  typedef struct { bit fin; logic [AW-1:0] pc; logic [7:0] cnt; int pulses; } end_t;

  int errors = 0;
  int checks = 0;
  logic [9:0] mirror [DEPTH];
  pulse_t pulse_q[$];
  end_t   end_q[$];
  bit     plan_ext[$];
  bit     plan_done[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Step-level reference: walks the processor's step plan, building expected pulses and final outcome.
  task automatic plan_run(input int len, input int mode, input int n, input logic [15:0] pe, input logic [15:0] pd);
    int pc, t, cnt, k, npc;
    bit e, d;
    pulse_t p;
    end_t r;
    pc = 0; t = 0; cnt = 0; k = 0;
    plan_ext.delete(); plan_done.delete();
    if (len == 0) begin
      r.fin = 1; r.pc = '0; r.cnt = '0; r.pulses = 0;
      end_q.push_back(r);
      return;
    end
    while (1) begin
      if (k < n) begin e = pe[k]; d = pd[k]; end
      else if (mode == 1) begin e = bit'($urandom_range(1)); d = 0; end
      else if (k >= 40) begin e = 1; d = 1; end
      else begin e = ($urandom_range(3) != 0); d = ($urandom_range(2) == 0); end
      plan_ext.push_back(e); plan_done.push_back(d);
      p.d = mirror[pc]; p.pc = pc[AW-1:0];
      pulse_q.push_back(p);
      k++;
      npc = pc + (e ? 1 : 0);
      if (d) begin cnt = (cnt < 255) ? cnt + 1 : 255; t = 0; end
      else t++;
      pc = npc % DEPTH;
      if (d && npc >= len) begin
        r.fin = 1; r.pc = pc[AW-1:0]; r.cnt = cnt[7:0]; r.pulses = k; end_q.push_back(r); break;
      end
      if (!d && t == MAX_T) begin
        r.fin = 0; r.pc = pc[AW-1:0]; r.cnt = cnt[7:0]; r.pulses = k; end_q.push_back(r); break;
      end
    end
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on each STEP rise and FIN/ERR rise.
  logic       prev_step = 1'b0, prev_fin = 1'b0, prev_err = 1'b0;
  int         lo_cnt = 0, hi_cnt = 0, run_pulses = 0;
  logic [9:0] d_hold = '0;
  pulse_t     mp;
  end_t       me;

  always @(negedge CLK50M) begin
    if (!RSTn) begin
      prev_step = 0; prev_fin = 0; prev_err = 0; lo_cnt = 0; hi_cnt = 0; run_pulses = 0;
    end else begin
      if (STEP && !prev_step) begin
        run_pulses++; hi_cnt = 1; d_hold = D_OUT;
        check("step_lo_width", lo_cnt, STEP_LO);
        if (pulse_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pulse: got pulse at PC=%0d expected none", PC);
        end else begin
          mp = pulse_q.pop_front();
          check("pulse_d_out", D_OUT, mp.d);
          check("pulse_pc", PC, mp.pc);
        end
      end else if (STEP) begin
        hi_cnt++;
        check("d_out_stable", D_OUT, d_hold);
      end else if (prev_step) begin
        check("step_hi_width", hi_cnt, STEP_HI);
        lo_cnt = BUSY ? 1 : 0;
      end else begin
        lo_cnt = BUSY ? lo_cnt + 1 : 0;
      end
      if ((FINISHED && !prev_fin) || (ERR && !prev_err)) begin
        if (end_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_end: got FINISHED=%0b ERR=%0b expected none", FINISHED, ERR);
        end else begin
          me = end_q.pop_front();
          check("end_finished", FINISHED, me.fin);
          check("end_err", ERR, !me.fin);
          check("end_pc", PC, me.pc);
          check("end_instr_cnt", INSTR_CNT, me.cnt);
          check("end_pulses", run_pulses, me.pulses);
          check("end_step_low", STEP, 0);
          check("end_busy", BUSY, 0);
        end
        run_pulses = 0;
      end
      prev_step = STEP; prev_fin = FINISHED; prev_err = ERR;
    end
  end

  task automatic junk();
    EXT = bit'($urandom_range(1));
    DONE = bit'($urandom_range(1));
    START = ($urandom_range(5) == 0);
    WR_EN = ($urandom_range(2) == 0);
    WR_ADDR = AW'($urandom_range(DEPTH - 1));
    WR_DATA = 10'($urandom);
  endtask

  task automatic quiet();
    EXT = 0; DONE = 0; START = 0; WR_EN = 0;
  endtask

  task automatic write_word(input int a, input logic [9:0] d);
    WR_EN = 1; WR_ADDR = AW'(a); WR_DATA = d;
    @(posedge CLK50M); #1;
    WR_EN = 0;
    mirror[a] = d;
  endtask

  task automatic do_reset();
    RSTn = 0; quiet();
    @(posedge CLK50M); @(posedge CLK50M); #1;
    pulse_q.delete(); end_q.delete();
    RSTn = 1;
  endtask

  // All calls start and end at #1 after a rising edge.
  task automatic run(input int len, input int mode, input int n, input logic [15:0] pe,
                     input logic [15:0] pd, input int abort_k);
    plan_run(len, mode, n, pe, pd);
    PROG_LEN = (AW+1)'(len); START = 1;
    @(posedge CLK50M); #1;
    START = 0;
    check("start_pc", PC, 0);
    check("start_instr_cnt", INSTR_CNT, 0);
    check("start_err", ERR, 0);
    check("start_busy", BUSY, len != 0);
    check("start_finished", FINISHED, len == 0);
    for (int k = 0; k < plan_ext.size(); k++) begin
      for (int c = 0; c < STEP_LO; c++) begin
        if (c == STEP_LO - 1) begin
          junk(); START = 0; EXT = plan_ext[k]; DONE = plan_done[k];
        end else junk();
        @(posedge CLK50M); #1;
      end
      if (k == abort_k) begin
        quiet();
        @(posedge CLK50M); #1;
        check("pre_reset_step", STEP, 1);
        RSTn = 0;
        #1;
        check("rst_step", STEP, 0);
        check("rst_pc", PC, 0);
        check("rst_busy", BUSY, 0);
        check("rst_instr_cnt", INSTR_CNT, 0);
        check("rst_d_out", D_OUT, mirror[0]);
        @(posedge CLK50M); @(posedge CLK50M); #1;
        pulse_q.delete(); end_q.delete();
        RSTn = 1;
        return;
      end
      for (int c = 0; c < STEP_HI; c++) begin
        junk();
        @(posedge CLK50M); #1;
      end
    end
    quiet();
    for (int i = 0; i < 50 && end_q.size() != 0; i++) @(posedge CLK50M);
    #1;
    if (end_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL end_timeout: got no FINISHED/ERR expected one within bound");
      end_q.delete();
    end
    check("pulses_left", pulse_q.size(), 0);
    pulse_q.delete();
    // Writes in FIN/ERROR must be ignored; the next run's D_OUT checks rely on it.
    for (int i = 0; i < 3; i++) begin
      WR_EN = 1; WR_ADDR = AW'($urandom_range(DEPTH - 1)); WR_DATA = 10'($urandom);
      @(posedge CLK50M); #1;
    end
    WR_EN = 0;
    check("idle_step_low", STEP, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge CLK50M); #1;
    check("reset_step", STEP, 0);
    check("reset_pc", PC, 0);
    check("reset_instr_cnt", INSTR_CNT, 0);
    check("reset_busy", BUSY, 0);
    check("reset_finished", FINISHED, 0);
    check("reset_err", ERR, 0);
    @(posedge CLK50M); #1;
    RSTn = 1;
    for (int a = 0; a < DEPTH; a++) write_word(a, 10'($urandom));
    write_word(0, 10'h2C1);
    write_word(1, 10'h155);
    check("reset_d_out", D_OUT, 10'h2C1);

    run(2, 0, 2, 16'b11, 16'b10, -1);              // single load: fetch + operand
    run(2, 0, 4, 16'b1001, 16'b1000, -1);          // ALU steps hold PC
    run(5, 1, 0, 16'h0, 16'h0, -1);                // no DONE: timeout after MAX_T pulses
    run(3, 0, 0, 16'h0, 16'h0, -1);                // restart from ERROR
    run(16, 0, 0, 16'h0, 16'h0, -1);               // full-depth program

    do_reset();
    run(0, 0, 0, 16'h0, 16'h0, -1);                // empty program
    run(8, 0, 4, 16'b1111, 16'b0101, 3);           // reset mid-pulse

    for (int r = 0; r < 12; r++) begin
      if ($urandom_range(1) == 1) begin
        do_reset();
        for (int i = 0; i < 4; i++) write_word($urandom_range(DEPTH - 1), 10'($urandom));
      end
      run($urandom_range(1, DEPTH), ($urandom_range(4) == 0) ? 1 : 0, 0, 16'h0, 16'h0, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
